mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle multiply/divide sequencer for the E stage of the pipelined CPU. It accepts one MDU operation per start pulse, holds `busy` for a fixed latency, and then commits the result into architectural HI/LO. It also serves MFHI/MFLO reads and MTHI/MTLO writes. An exception request (`req`) from CP0 cancels only the operation being launched in that cycle. The hazard unit stalls D whenever `start | busy` and the D-stage instruction is an MDU instruction.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: launch the MULT/MULTU/DIV/DIVU op given on `mduOp` this cycle.
- `mduOp`  in  4: 0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MFHI, 0110 MFLO, 0111 MTHI, 1000 MTLO.
- `srcA`  in  32: forwarded rs value.
- `srcB`  in  32: forwarded rt value.
- `req`  in  1: exception/interrupt taken this cycle; suppresses the launch and MT writes of this cycle.
- `busy`  out  1: operation in flight.
- `hi`  out  32: architectural HI.
- `lo`  out  32: architectural LO.
- `mduOut`  out  32: combinational; `hi` for MFHI, `lo` for MFLO, otherwise 0.

## Operation
- **States:** IDLE and BUSY. Counter `cnt` is 4 bits, wide enough for `DIV_CYCLES`.
- **Launch (IDLE):** on `start & !req` with a MULT/MULTU/DIV/DIVU op:
  - Compute the result from `srcA`/`srcB` this cycle and latch it into shadow registers `hi_s`/`lo_s`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`, go to BUSY.
- **BUSY:**
  - `cnt` decrements each cycle.
  - On the edge where `cnt==1`, HI/LO take `hi_s`/`lo_s`, `cnt` goes to 0, and the state returns to IDLE.
- **Arithmetic:**
  - MULT: signed 32x32 to 64; HI gets bits [63:32], LO gets [31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; LO is the quotient truncated toward zero, HI is the remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divide by zero: at commit, HI/LO stay unchanged; `busy` still runs the full `DIV_CYCLES`.
- **MTHI/MTLO:** when `mduOp` is MTHI/MTLO and `!req`, `srcA` is written into HI/LO on the next edge. No `busy`, allowed only in IDLE.
- **MFHI/MFLO:** read architectural `hi`/`lo`; values from an in-flight operation are never visible.
- **Precedence:**
  - `start` or MT while BUSY is ignored. The hazard unit guarantees this never happens; the bench asserts it.
  - `req` while BUSY does not abort; the in-flight op belongs to an older, committed instruction.
- **Reset:** asserting `reset` low mid-operation clears the state to IDLE, `cnt` to 0, HI, LO, `hi_s`, `lo_s` to 0.
- **Reset values:** `busy`=0, `hi`=0, `lo`=0, `mduOut`=0.

## Timing
- Start accepted at edge T0. `busy` is high for exactly N cycles (T0..T0+N). HI/LO update at edge T0+N, and `busy` is low from that edge on.
- `start` is high in the launch cycle while `busy` is still low. The stall condition therefore uses `start|busy`, giving N+1 stall cycles for a dependent MDU instruction in D.
- MTHI/MTLO have a 1-edge latency. `mduOut` has zero latency (combinational from `hi`/`lo`/`mduOp`).
- A new start is legal on the cycle after `busy` falls. There is no back-to-back overlap.

## Structure
- Package `mdu_pkg`: the `mduOp` encodings (`MDU_NONE` … `MDU_MTLO`), and the `MULT_CYCLES`/`DIV_CYCLES` defaults.
- Sub-module `mdu_arith`, purely combinational: `mduOp`, `srcA`, `srcB` in; `hi_res`, `lo_res` and `div0` out. It isolates the signed/unsigned multiply and divide from the sequencing FSM.

## Test plan
1. MULT with A=0xFFFFFFFE (-2), B=3 -> `busy` high 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO during busy returns the old LO.
2. DIV with A=-7, B=2 -> `busy` high 10 cycles; afterwards LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU with A=7, B=0 -> 10 busy cycles, HI/LO unchanged.
3. MTHI with A=0x12345678, then MFHI next cycle -> `mduOut`=0x12345678; MTLO together with `req`=1 -> LO unchanged.
4. `start`=1 with MULTU, A=B=0xFFFFFFFF, `req`=1 -> `busy` never rises, HI/LO unchanged. Retry with `req`=0 -> HI=0xFFFFFFFE, LO=0x00000001.
5. Pull `reset` low at busy cycle 3 of a DIV -> `busy`=0, HI=LO=0 asynchronously. After release, a MULT with A=4, B=5 -> LO=20 after 5 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU operation encodings, latency defaults and op-class helpers
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_arith(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || is_div(op);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational signed/unsigned multiply and divide for the MDU
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  mduOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign div0    = (srcB == 32'd0);
    // A zero divisor is swapped for 1 so the dividers never produce X; the result is discarded at commit.
    assign divisor = div0 ? 32'd1 : srcB;

    assign prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
    assign prod_u = {32'd0, srcA} * {32'd0, srcB};
    assign q_s    = $signed(srcA) / $signed(divisor);
    assign r_s    = $signed(srcA) % $signed(divisor);
    assign q_u    = srcA / divisor;
    assign r_u    = srcA % divisor;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (mduOp)
            MDU_MULT:  begin hi_res = prod_s[63:32]; lo_res = prod_s[31:0]; end
            MDU_MULTU: begin hi_res = prod_u[63:32]; lo_res = prod_u[31:0]; end
            MDU_DIV:   begin hi_res = r_s;           lo_res = q_s;          end
            MDU_DIVU:  begin hi_res = r_u;           lo_res = q_u;          end
            default:   ;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - fixed-latency MDU sequencer owning architectural HI/LO
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = mdu_pkg::MULT_CYCLES,
    parameter int DIV_CYCLES  = mdu_pkg::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mduOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mduOut
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_s_q, hi_s_d, lo_s_q, lo_s_d;
    logic        div0_q, div0_d;
    logic        busy_q, busy_d;

    logic [31:0] hi_res;
    logic [31:0] lo_res;
    logic        div0;

    mdu_arith u_arith (
        .mduOp  (mduOp),
        .srcA   (srcA),
        .srcB   (srcB),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_s_d  = hi_s_q;
        lo_s_d  = lo_s_q;
        div0_d  = div0_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (!req) begin
                    if (start && is_arith(mduOp)) begin
                        hi_s_d  = hi_res;
                        lo_s_d  = lo_res;
                        div0_d  = div0 && is_div(mduOp);
                        cnt_d   = is_div(mduOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state_d = ST_BUSY;
                        busy_d  = 1'b1;
                    end else if (mduOp == MDU_MTHI) begin
                        hi_d = srcA;
                    end else if (mduOp == MDU_MTLO) begin
                        lo_d = srcA;
                    end
                end
            end
            ST_BUSY: begin
                // req is deliberately ignored here: the in-flight op is already architecturally committed.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!div0_q) begin
                        hi_d = hi_s_q;
                        lo_d = lo_s_q;
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_s_q  <= 32'd0;
            lo_s_q  <= 32'd0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_s_q  <= hi_s_d;
            lo_s_q  <= lo_s_d;
            div0_q  <= div0_d;
            busy_q  <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign mduOut = (mduOp == MDU_MFHI) ? hi_q :
                    (mduOp == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed table-driven bench for mdu_sequencer
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mduOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mduOut;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          ncyc;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[8];

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mduOp  (mduOp),
        .srcA   (srcA),
        .srcB   (srcB),
        .req    (req),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .mduOut (mduOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Hazard-unit contract: no start or MT may reach the sequencer while busy.
    always @(posedge clk) begin
        if (reset && busy && (start || mduOp == MDU_MTHI || mduOp == MDU_MTLO)) begin
            n_checks++;
            $display("FAIL protocol: start/MT issued while busy (op=%0d)", mduOp);
        end
    end

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic [31:0] old_lo, input bit req_in_busy);
        int cnt;
        @(negedge clk);
        start = 1'b1; mduOp = op; srcA = a; srcB = b; req = 1'b0;
        @(negedge clk);
        start = 1'b0; mduOp = MDU_MFLO; srcA = 32'd0; srcB = 32'd0;
        #1;
        check({name, " mflo_during_busy"}, mduOut, old_lo);
        mduOp = MDU_NONE;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (req_in_busy) req = 1'b1;
            @(negedge clk);
        end
        req = 1'b0;
        check({name, " busy_cycles"}, 32'(cnt), 32'(ncyc));
        check({name, " hi"}, hi, ehi);
        check({name, " lo"}, lo, elo);
    endtask

    initial begin
        logic [31:0] prev_lo;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0; start = 1'b0; mduOp = MDU_NONE; srcA = 32'd0; srcB = 32'd0; req = 1'b0;

        vecs[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[2] = '{MDU_DIVU,  32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{MDU_MULTU, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
        vecs[4] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[5] = '{MDU_DIVU,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
        vecs[6] = '{MDU_MULT,  32'h80000000, 32'd2,        5,  32'hFFFFFFFF, 32'h00000000};
        vecs[7] = '{MDU_DIV,   32'd5,        32'd0,        10, 32'hFFFFFFFF, 32'h00000000};

        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset mduOut", mduOut, 32'd0);
        reset = 1'b1;

        prev_lo = 32'd0;
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].ncyc, vecs[i].ehi, vecs[i].elo, prev_lo, 1'b0);
            prev_lo = vecs[i].elo;
        end

        // MTHI then MFHI; MTLO suppressed by req; MTLO without req
        @(negedge clk);
        mduOp = MDU_MTHI; srcA = 32'h12345678;
        @(negedge clk);
        mduOp = MDU_MFHI; srcA = 32'd0;
        #1;
        check("mthi->mfhi mduOut", mduOut, 32'h12345678);
        @(negedge clk);
        mduOp = MDU_MTLO; srcA = 32'hDEADBEEF; req = 1'b1;
        @(negedge clk);
        mduOp = MDU_MFLO; req = 1'b0;
        #1;
        check("mtlo with req lo", lo, 32'h00000000);
        @(negedge clk);
        mduOp = MDU_MTLO; srcA = 32'hCAFEF00D;
        @(negedge clk);
        mduOp = MDU_MFLO; srcA = 32'd0;
        #1;
        check("mtlo->mflo mduOut", mduOut, 32'hCAFEF00D);
        mduOp = MDU_NONE;

        // start cancelled by req in the launch cycle
        @(negedge clk);
        start = 1'b1; mduOp = MDU_MULTU; srcA = 32'hFFFFFFFF; srcB = 32'hFFFFFFFF; req = 1'b1;
        @(negedge clk);
        start = 1'b0; mduOp = MDU_NONE; req = 1'b0;
        check("req cancel busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("req cancel busy later", {31'd0, busy}, 32'd0);
        check("req cancel hi", hi, 32'h12345678);
        check("req cancel lo", lo, 32'hCAFEF00D);
        run_op("multu retry", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
               32'hFFFFFFFE, 32'h00000001, 32'hCAFEF00D, 1'b0);

        // req during busy must not abort
        run_op("mult req_in_busy", MDU_MULT, 32'd3, 32'd3, 5,
               32'h00000000, 32'h00000009, 32'h00000001, 1'b1);

        // asynchronous reset at busy cycle 3 of a DIV
        @(negedge clk);
        start = 1'b1; mduOp = MDU_DIV; srcA = 32'd100; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0; mduOp = MDU_NONE;
        repeat (2) @(negedge clk);
        check("busy before reset", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset hi", hi, 32'd0);
        check("async reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("mult after reset", MDU_MULT, 32'd4, 32'd5, 5,
               32'h00000000, 32'd20, 32'd0, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
